// File: rtl/periph_bus.sv
// Single-master request router to RAM, UART and timer windows.
// Requests are forwarded as one-cycle pulses; responses, decode misses and slave timeouts return as registered pulses.
module periph_bus #(
    parameter logic [31:0] RAM_BASE   = 32'h0000_0000,
    parameter logic [31:0] RAM_SIZE   = 32'h0010_0000,
    parameter logic [31:0] UART_BASE  = 32'h1000_0000,
    parameter logic [31:0] UART_SIZE  = 32'h0000_0010,
    parameter logic [31:0] TIMER_BASE = 32'h2000_0000,
    parameter logic [31:0] TIMER_SIZE = 32'h0000_0010,
    parameter int          TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        ram_valid,
    output logic        ram_instr,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ready,
    output logic        uart_valid,
    output logic        uart_instr,
    output logic [31:0] uart_addr,
    output logic [31:0] uart_wdata,
    output logic [3:0]  uart_wstrb,
    input  logic [31:0] uart_rdata,
    input  logic        uart_ready,
    output logic        timer_valid,
    output logic        timer_instr,
    output logic [31:0] timer_addr,
    output logic [31:0] timer_wdata,
    output logic [3:0]  timer_wstrb,
    input  logic [31:0] timer_rdata,
    input  logic        timer_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;
    typedef enum logic [1:0] {SEL_RAM, SEL_UART, SEL_TIMER} sel_t;

    state_t           state, state_d;
    sel_t             sel, sel_d, dec_sel;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             hit_any, accept, miss, done_ok, done_to;
    logic             sel_ready;
    logic [31:0]      sel_rdata;

    // 33-bit compare so a window ending at 2^32 never wraps to match low addresses
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] a, lo, hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

    always_comb begin
        dec_sel = SEL_RAM;
        hit_any = 1'b1;
        if (in_window(mem_addr, TIMER_BASE, TIMER_SIZE))
            dec_sel = SEL_TIMER;
        else if (in_window(mem_addr, UART_BASE, UART_SIZE))
            dec_sel = SEL_UART;
        else if (!in_window(mem_addr, RAM_BASE, RAM_SIZE))
            hit_any = 1'b0;
    end

    always_comb begin
        case (sel)
            SEL_UART:  begin sel_ready = uart_ready;  sel_rdata = uart_rdata;  end
            SEL_TIMER: begin sel_ready = timer_ready; sel_rdata = timer_rdata; end
            default:   begin sel_ready = ram_ready;   sel_rdata = ram_rdata;   end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            sel   <= SEL_RAM;
            cnt   <= '0;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            cnt   <= cnt_d;
        end
    end

    // cnt is 0 while the slave valid pulse is out, so readiness is only honoured from V+1
    always_comb begin
        state_d = state;
        sel_d   = sel;
        cnt_d   = cnt;
        accept  = 1'b0;
        miss    = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (hit_any) begin
                        accept  = 1'b1;
                        sel_d   = dec_sel;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        miss = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt != '0 && sel_ready) begin
                    done_ok = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    done_to = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_rdata   <= '0;
            mem_ready   <= 1'b0;
            mem_error   <= 1'b0;
            ram_valid   <= 1'b0;
            ram_instr   <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_wstrb   <= '0;
            uart_valid  <= 1'b0;
            uart_instr  <= 1'b0;
            uart_addr   <= '0;
            uart_wdata  <= '0;
            uart_wstrb  <= '0;
            timer_valid <= 1'b0;
            timer_instr <= 1'b0;
            timer_addr  <= '0;
            timer_wdata <= '0;
            timer_wstrb <= '0;
        end else begin
            mem_ready <= miss | done_ok | done_to;
            mem_error <= miss | done_to;
            if (miss || done_to)
                mem_rdata <= '0;
            else if (done_ok)
                mem_rdata <= sel_rdata;

            ram_valid   <= accept && (dec_sel == SEL_RAM);
            uart_valid  <= accept && (dec_sel == SEL_UART);
            timer_valid <= accept && (dec_sel == SEL_TIMER);

            if (accept && dec_sel == SEL_RAM) begin
                ram_instr <= mem_instr;
                ram_addr  <= mem_addr - RAM_BASE;
                ram_wdata <= mem_wdata;
                ram_wstrb <= mem_wstrb;
            end
            if (accept && dec_sel == SEL_UART) begin
                uart_instr <= mem_instr;
                uart_addr  <= mem_addr - UART_BASE;
                uart_wdata <= mem_wdata;
                uart_wstrb <= mem_wstrb;
            end
            if (accept && dec_sel == SEL_TIMER) begin
                timer_instr <= mem_instr;
                timer_addr  <= mem_addr - TIMER_BASE;
                timer_wdata <= mem_wdata;
                timer_wstrb <= mem_wstrb;
            end
        end
    end

endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus: inputs are applied and outputs checked on the falling edge.
`timescale 1ns/1ps
module tb_periph_bus;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready, mem_error;
    logic        ram_valid, ram_instr, uart_valid, uart_instr, timer_valid, timer_instr;
    logic [31:0] ram_addr, ram_wdata, uart_addr, uart_wdata, timer_addr, timer_wdata;
    logic [3:0]  ram_wstrb, uart_wstrb, timer_wstrb;
    logic [31:0] ram_rdata, uart_rdata, timer_rdata;
    logic        ram_ready, uart_ready, timer_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] miss_addrs [3];

    always #5 clk = ~clk;

    periph_bus dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_error(mem_error),
        .ram_valid(ram_valid), .ram_instr(ram_instr), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
        .uart_valid(uart_valid), .uart_instr(uart_instr), .uart_addr(uart_addr),
        .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb), .uart_rdata(uart_rdata), .uart_ready(uart_ready),
        .timer_valid(timer_valid), .timer_instr(timer_instr), .timer_addr(timer_addr),
        .timer_wdata(timer_wdata), .timer_wstrb(timer_wstrb), .timer_rdata(timer_rdata), .timer_ready(timer_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; pulse inputs default back to 0.
    task automatic tick();
        @(negedge clk);
        mem_valid   = 1'b0;
        ram_ready   = 1'b0;
        uart_ready  = 1'b0;
        timer_ready = 1'b0;
    endtask

    task automatic req(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic instr);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_instr = instr;
    endtask

    task automatic chk_resp(input string tag, input logic rdy, input logic err);
        chk({tag, "_ready"}, 32'(mem_ready), 32'(rdy));
        chk({tag, "_error"}, 32'(mem_error), 32'(err));
    endtask

    task automatic chk_valids(input string tag, input logic r, input logic u, input logic t);
        chk({tag, "_ram_valid"},   32'(ram_valid),   32'(r));
        chk({tag, "_uart_valid"},  32'(uart_valid),  32'(u));
        chk({tag, "_timer_valid"}, 32'(timer_valid), 32'(t));
    endtask

    initial begin
        rst = 1'b0;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        ram_rdata = '0; uart_rdata = '0; timer_rdata = '0;
        ram_ready = 1'b0; uart_ready = 1'b0; timer_ready = 1'b0;
        miss_addrs[0] = 32'h3000_0000;
        miss_addrs[1] = 32'h2000_0010;
        miss_addrs[2] = 32'hFFFF_FFFF;

        tick(); tick();
        chk_resp("rst", 1'b0, 1'b0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk_valids("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();

        // 1: timer read
        tick(); req(32'h2000_0008, 32'h0, 4'h0, 1'b0);
        tick(); chk_valids("t1_c1", 1'b0, 1'b0, 1'b1);
        chk("t1_timer_addr", timer_addr, 32'h8);
        chk("t1_timer_wstrb", 32'(timer_wstrb), 32'h0);
        chk_resp("t1_c1", 1'b0, 1'b0);
        tick(); timer_ready = 1'b1; timer_rdata = 32'h0000_1234;
        chk_valids("t1_c2", 1'b0, 1'b0, 1'b0);
        chk_resp("t1_c2", 1'b0, 1'b0);
        tick(); chk_resp("t1_c3", 1'b1, 1'b0);
        chk("t1_rdata", mem_rdata, 32'h0000_1234);
        tick(); chk_resp("t1_c4", 1'b0, 1'b0);
        chk("t1_rdata_hold", mem_rdata, 32'h0000_1234);

        // 2: RAM write, slave answers two cycles after valid
        tick(); req(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0);
        tick(); chk_valids("t2_c1", 1'b1, 1'b0, 1'b0);
        chk("t2_ram_addr", ram_addr, 32'h100);
        chk("t2_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("t2_ram_wstrb", 32'(ram_wstrb), 32'hF);
        tick(); chk_valids("t2_c2", 1'b0, 1'b0, 1'b0);
        tick(); ram_ready = 1'b1; ram_rdata = 32'h0000_A5A5;
        chk_resp("t2_c3", 1'b0, 1'b0);
        tick(); chk_resp("t2_c4", 1'b1, 1'b0);
        chk("t2_rdata", mem_rdata, 32'h0000_A5A5);

        // 3: unmapped addresses, then a timer hit at the last window byte
        for (int i = 0; i < 3; i++) begin
            tick(); req(miss_addrs[i], 32'h0, 4'h0, 1'b0);
            tick(); chk_resp("t3_miss", 1'b1, 1'b1);
            chk("t3_miss_rdata", mem_rdata, 32'h0);
            chk_valids("t3_miss", 1'b0, 1'b0, 1'b0);
            tick(); chk_resp("t3_after", 1'b0, 1'b0);
            chk_valids("t3_after", 1'b0, 1'b0, 1'b0);
        end
        tick(); req(32'h2000_000F, 32'h0, 4'h0, 1'b1);
        tick(); chk_valids("t3_ctl", 1'b0, 1'b0, 1'b1);
        chk("t3_timer_addr", timer_addr, 32'hF);
        chk("t3_timer_instr", 32'(timer_instr), 32'h1);
        tick(); timer_ready = 1'b1; timer_rdata = 32'h0000_00F0;
        tick(); chk_resp("t3_ctl", 1'b1, 1'b0);
        chk("t3_ctl_rdata", mem_rdata, 32'h0000_00F0);

        // 4: UART never answers; stray readies and a mid-wait request are ignored
        tick(); req(32'h1000_0004, 32'h0, 4'h0, 1'b0);
        tick(); chk_valids("t4_c1", 1'b0, 1'b1, 1'b0);
        chk("t4_uart_addr", uart_addr, 32'h4);
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (c == 5) begin ram_ready = 1'b1; timer_ready = 1'b1; end
            if (c == 8) req(32'h0000_0300, 32'h0, 4'h0, 1'b0);
            chk_resp("t4_wait", 1'b0, 1'b0);
            chk_valids("t4_wait", 1'b0, 1'b0, 1'b0);
        end
        tick(); chk_resp("t4_c18", 1'b1, 1'b1);
        chk("t4_rdata", mem_rdata, 32'h0);
        tick(); chk_resp("t4_c19", 1'b0, 1'b0);
        tick(); uart_ready = 1'b1; uart_rdata = 32'h0000_0077;
        chk_resp("t4_c20", 1'b0, 1'b0);
        tick(); chk_resp("t4_c21", 1'b0, 1'b0);
        chk_valids("t4_c21", 1'b0, 1'b0, 1'b0);
        tick(); chk_resp("t4_c22", 1'b0, 1'b0);

        // 5: UART answers exactly at V+TIMEOUT, then a back-to-back RAM read
        tick(); req(32'h1000_0008, 32'h0, 4'h0, 1'b0);
        tick(); chk_valids("t5_c1", 1'b0, 1'b1, 1'b0);
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (c == 17) begin uart_ready = 1'b1; uart_rdata = 32'h0000_0055; end
            chk_resp("t5_wait", 1'b0, 1'b0);
        end
        tick(); req(32'h0000_0200, 32'h0, 4'h0, 1'b0);
        chk_resp("t5_c18", 1'b1, 1'b0);
        chk("t5_rdata", mem_rdata, 32'h0000_0055);
        tick(); chk_valids("t5_b2b", 1'b1, 1'b0, 1'b0);
        chk("t5_ram_addr", ram_addr, 32'h200);
        chk_resp("t5_c19", 1'b0, 1'b0);
        tick(); ram_ready = 1'b1; ram_rdata = 32'h1111_2222;
        tick(); chk_resp("t5_c21", 1'b1, 1'b0);
        chk("t5_b2b_rdata", mem_rdata, 32'h1111_2222);

        // 6: reset during a pending timer read
        tick(); req(32'h2000_000C, 32'hCAFE_0000, 4'h3, 1'b1);
        tick(); chk_valids("t6_c1", 1'b0, 1'b0, 1'b1);
        tick(); rst = 1'b0;
        tick(); rst = 1'b1;
        chk_resp("t6_c3", 1'b0, 1'b0);
        chk("t6_rdata", mem_rdata, 32'h0);
        chk("t6_timer_addr", timer_addr, 32'h0);
        chk("t6_timer_wdata", timer_wdata, 32'h0);
        chk("t6_ram_addr", ram_addr, 32'h0);
        chk("t6_timer_instr", 32'(timer_instr), 32'h0);
        tick(); timer_ready = 1'b1; timer_rdata = 32'h0000_9999;
        chk_resp("t6_c4", 1'b0, 1'b0);
        tick(); chk_resp("t6_c5", 1'b0, 1'b0);
        tick(); chk_resp("t6_c6", 1'b0, 1'b0);
        chk("t6_c6_rdata", mem_rdata, 32'h0);
        tick(); req(32'h2000_0004, 32'h0, 4'h0, 1'b0);
        tick(); chk_valids("t6_next", 1'b0, 1'b0, 1'b1);
        chk("t6_next_addr", timer_addr, 32'h4);
        tick(); timer_ready = 1'b1; timer_rdata = 32'h0000_BEEF;
        tick(); chk_resp("t6_next", 1'b1, 1'b0);
        chk("t6_next_rdata", mem_rdata, 32'h0000_BEEF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_bus.md
Name: periph_bus

Overview:
- Single-master to three-slave memory-mapped request router between the core's data port and the peripherals: RAM, UART and timer.
- Decodes each request address and forwards the request with a base-relative offset as a one-cycle valid pulse.
- Returns the selected slave's response to the master.
- Generates error responses for unmapped addresses and for slaves that do not answer within a bounded time.

Parameters:
RAM_BASE, 32'h00000000, RAM window base
RAM_SIZE, 32'h00100000, RAM window size in bytes
UART_BASE, 32'h10000000, UART window base
UART_SIZE, 32'h00000010, UART window size
TIMER_BASE, 32'h20000000, timer window base
TIMER_SIZE, 32'h00000010, timer window size
TIMEOUT, 16, max cycles to wait for slave ready (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
mem_valid  in  1  request pulse, one cycle
mem_instr  in  1  instruction-fetch flag
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte enables; 0 = read
mem_rdata  out  32  response data
mem_ready  out  1  response pulse, one cycle
mem_error  out  1  error flag, valid with mem_ready
Slave bundle, repeated for S in {ram, uart, timer}:
S_valid  out  1  request pulse
S_instr  out  1  forwarded mem_instr
S_addr  out  32  mem_addr - S_BASE
S_wdata  out  32  forwarded mem_wdata
S_wstrb  out  4  forwarded mem_wstrb
S_rdata  in  32  slave read data
S_ready  in  1  slave response pulse

Behaviour:
- Reset: rst is synchronous, active-low; clk is the only clock.
  - All outputs register to 0 under reset.
  - State goes to IDLE and the wait counter clears.
- All outputs are registered. No combinational path runs from input to output.
- Decode:
  - Hit if BASE <= addr < BASE+SIZE, computed 33 bits wide, so windows never wrap past 2^32.
  - If windows overlap, priority is timer > uart > ram.
  - Alignment is not checked.
- IDLE, mem_valid=1 at cycle 0:
  - On a hit: capture the request; at cycle V=1 the selected S_valid=1 for exactly one cycle, with offset address and forwarded fields; go to WAIT.
  - On a miss: at cycle 1, mem_ready=1, mem_error=1, mem_rdata=0; stay IDLE; no S_valid asserted.
- WAIT:
  - Sample only the selected slave's S_ready, from cycle V+1 onward.
  - S_ready=1 at cycle V+d, with 1<=d<=TIMEOUT: at V+d+1, mem_ready=1, mem_rdata = captured S_rdata, mem_error=0; go to IDLE.
  - No S_ready by V+TIMEOUT: at V+TIMEOUT+1, mem_ready=1, mem_error=1, mem_rdata=0; go to IDLE.
  - S_ready exactly at V+TIMEOUT counts as success; success wins over timeout.
- Best-case latency for a slave answering one cycle after valid: mem_ready 3 cycles after mem_valid.
- Non-selected S_ready is always ignored. Any S_ready seen in IDLE is ignored, including late responses after a timeout.
- mem_valid while in WAIT is dropped; this is a master protocol violation. mem_valid in the same cycle as a mem_ready is accepted normally.
- mem_ready, mem_error and S_valid are single-cycle pulses. They return to 0 the following cycle.
- mem_rdata and S_addr/S_wdata/S_wstrb/S_instr hold their last values between pulses.
- Reset mid-WAIT: go to IDLE; no mem_ready is ever produced for the aborted request.

Test Plan:
1. Timer read, mem_addr=0x20000008, wstrb=0, at cycle 0; slave model gives timer_ready at cycle 2 with rdata 0x00001234 -> timer_valid=1 at cycle 1 with timer_addr=8; mem_ready=1 at cycle 3 with rdata 0x00001234, error=0; ram_valid and uart_valid stay 0.
2. RAM write, mem_addr=0x00000100, wdata=0xDEADBEEF, wstrb=0xF -> ram_valid=1 with ram_addr=0x100, ram_wstrb=0xF, ram_wdata=0xDEADBEEF; mem_ready follows ram_ready by 1 cycle.
3. Unmapped accesses at 0x30000000, 0x20000010 and 0xFFFFFFFF -> each gives mem_ready=1, mem_error=1, rdata=0 one cycle after mem_valid; no S_valid asserted. Control case: 0x2000000F hits timer with timer_addr=0xF.
4. UART never ready, TIMEOUT=16, uart_valid at cycle 1 -> mem_ready=1, mem_error=1 at cycle 18; a uart_ready at cycle 20 produces no response.
5. Boundary on timeout: uart_ready at cycle 17 (V+16) -> success at 18 with error=0. Back-to-back: a new mem_valid in the mem_ready cycle is forwarded the next cycle.
6. rst=0 for one cycle at cycle 2 of a pending timer read, then timer_ready at cycle 4 -> no mem_ready; all outputs 0 after reset; next request completes normally.
